// File: rtl/rst_pkg.sv
// rtl/rst_pkg.sv - shared defaults and table entry type for the rename status table
package rst_pkg;

  localparam int RST_NREG  = 32;
  localparam int RST_ROBW  = 3;
  localparam int RST_NCKPT = 4;

  // One scoreboard entry: is the register waiting on an in-flight producer, and which one.
  typedef struct packed {
    logic                busy;
    logic [RST_ROBW-1:0] tag;
  } rst_entry_t;

  // True when a commit of tag t retires the producer this entry is waiting on.
  function automatic logic rst_tag_hit(input rst_entry_t e, input logic [RST_ROBW-1:0] t);
    return e.busy && (e.tag == t);
  endfunction

endpackage

// File: rtl/rst_ckpt_ring.sv
// rtl/rst_ckpt_ring.sv - head/tail/count bookkeeping for the branch checkpoint ring
module rst_ckpt_ring #(
  parameter  int NCKPT = 4,
  localparam int CW    = $clog2(NCKPT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_flush,
  input  logic          i_restore,
  input  logic [CW-1:0] i_restore_id,
  input  logic          i_ckpt_req,
  input  logic          i_release,
  output logic          o_alloc,
  output logic [CW-1:0] o_tail,
  output logic [CW:0]   o_count,
  output logic          o_full
);

  localparam logic [CW:0] FULL_CNT = (CW+1)'(NCKPT);

  logic [CW-1:0] r_head;
  logic [CW-1:0] r_tail;
  logic [CW:0]   r_count;
  logic          w_rel;

  // Allocation and release only happen in a plain cycle; flush and restore own the pointers.
  assign o_full  = (r_count == FULL_CNT);
  assign o_alloc = i_ckpt_req && !o_full && !i_restore && !i_flush;
  assign w_rel   = i_release && (r_count != '0) && !i_restore && !i_flush;
  assign o_tail  = r_tail;
  assign o_count = r_count;

  // Pointer and occupancy update; pointers wrap naturally since NCKPT is a power of two.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_restore) begin
      // Everything younger than the restored slot is discarded, including the slot itself.
      r_tail  <= i_restore_id;
      r_count <= {1'b0, i_restore_id - r_head};
    end else begin
      if (o_alloc) r_tail <= r_tail + CW'(1);
      if (w_rel)   r_head <= r_head + CW'(1);
      case ({o_alloc, w_rel})
        2'b10:   r_count <= r_count + (CW+1)'(1);
        2'b01:   r_count <= r_count - (CW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rename_status_table.sv
// rtl/rename_status_table.sv - register busy/tag scoreboard with branch checkpoints
module rename_status_table
  import rst_pkg::*;
#(
  parameter  int NREG  = RST_NREG,
  parameter  int ROBW  = RST_ROBW,
  parameter  int NCKPT = RST_NCKPT,
  localparam int IW    = $clog2(NREG),
  localparam int CW    = $clog2(NCKPT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IW-1:0]   rs1,
  input  logic [IW-1:0]   rs2,
  output logic            src_busy1,
  output logic            src_busy2,
  output logic [ROBW-1:0] src_tag1,
  output logic [ROBW-1:0] src_tag2,
  input  logic            ren_valid,
  input  logic [IW-1:0]   ren_rd,
  input  logic [ROBW-1:0] ren_tag,
  input  logic            cmt_valid,
  input  logic [IW-1:0]   cmt_rd,
  input  logic [ROBW-1:0] cmt_tag,
  input  logic            ckpt_req,
  output logic [CW-1:0]   ckpt_id,
  output logic            ckpt_full,
  output logic [CW:0]     ckpt_count,
  input  logic            release_valid,
  input  logic            restore_valid,
  input  logic [CW-1:0]   restore_id,
  input  logic            flush
);

  // The entry type carries a fixed tag width, so the tag parameter must match it.
  if (ROBW != RST_ROBW) begin : g_bad_robw
    $error("rename_status_table: ROBW must equal rst_pkg::RST_ROBW");
  end
  if ((1 << CW) != NCKPT) begin : g_bad_nckpt
    $error("rename_status_table: NCKPT must be a power of two");
  end

  rst_entry_t r_tab [NREG];
  rst_entry_t r_ck  [NCKPT][NREG];
  rst_entry_t w_tab_nxt [NREG];
  rst_entry_t w_ck_nxt  [NCKPT][NREG];

  logic          w_ren_en;
  logic          w_cmt_en;
  logic          w_alloc;
  logic [CW-1:0] w_tail;

  rst_entry_t    w_ent1;
  rst_entry_t    w_ent2;
  logic          w_byp1;
  logic          w_byp2;
  logic          w_fwd1;
  logic          w_fwd2;

  rst_ckpt_ring #(
    .NCKPT (NCKPT)
  ) u_ring (
    .clk          (clk),
    .reset        (reset),
    .i_flush      (flush),
    .i_restore    (restore_valid),
    .i_restore_id (restore_id),
    .i_ckpt_req   (ckpt_req),
    .i_release    (release_valid),
    .o_alloc      (w_alloc),
    .o_tail       (w_tail),
    .o_count      (ckpt_count),
    .o_full       (ckpt_full)
  );

  assign ckpt_id = w_tail;

  // Register 0 is hard-wired ready, so writes to it are dropped at the source.
  assign w_ren_en = ren_valid && (ren_rd != '0) && !restore_valid && !flush;
  assign w_cmt_en = cmt_valid && (cmt_rd != '0) && !flush;

  // Lookups see the same-cycle rename first, then the same-cycle commit, then the stored entry.
  assign w_ent1    = r_tab[rs1];
  assign w_ent2    = r_tab[rs2];
  assign w_byp1    = ren_valid && (ren_rd != '0) && (ren_rd == rs1);
  assign w_byp2    = ren_valid && (ren_rd != '0) && (ren_rd == rs2);
  assign w_fwd1    = cmt_valid && (cmt_rd == rs1) && rst_tag_hit(w_ent1, cmt_tag);
  assign w_fwd2    = cmt_valid && (cmt_rd == rs2) && rst_tag_hit(w_ent2, cmt_tag);
  assign src_busy1 = (rs1 != '0) && (w_byp1 || (w_ent1.busy && !w_fwd1));
  assign src_busy2 = (rs2 != '0) && (w_byp2 || (w_ent2.busy && !w_fwd2));
  assign src_tag1  = w_byp1 ? ren_tag : w_ent1.tag;
  assign src_tag2  = w_byp2 ? ren_tag : w_ent2.tag;

  // Next live table: pick base (restore copy or current), retire the commit, then let rename win.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      w_tab_nxt[r] = restore_valid ? r_ck[restore_id][r] : r_tab[r];
      if (w_cmt_en && (cmt_rd == IW'(r)) && rst_tag_hit(w_tab_nxt[r], cmt_tag)) begin
        w_tab_nxt[r].busy = 1'b0;
      end
      if (w_ren_en && (ren_rd == IW'(r))) begin
        w_tab_nxt[r].busy = 1'b1;
        w_tab_nxt[r].tag  = ren_tag;
      end
      if (flush) begin
        w_tab_nxt[r].busy = 1'b0;
      end
    end
  end

  // Next checkpoint contents: commits retire matching producers in every slot; allocation snapshots.
  always_comb begin
    for (int s = 0; s < NCKPT; s++) begin
      for (int r = 0; r < NREG; r++) begin
        w_ck_nxt[s][r] = r_ck[s][r];
        if (w_cmt_en && (cmt_rd == IW'(r)) && rst_tag_hit(r_ck[s][r], cmt_tag)) begin
          w_ck_nxt[s][r].busy = 1'b0;
        end
        if (w_alloc && (w_tail == CW'(s))) begin
          w_ck_nxt[s][r] = w_tab_nxt[r];
        end
      end
    end
  end

  // Table and checkpoint storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        r_tab[r] <= '0;
      end
      for (int s = 0; s < NCKPT; s++) begin
        for (int r = 0; r < NREG; r++) begin
          r_ck[s][r] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        r_tab[r] <= w_tab_nxt[r];
      end
      for (int s = 0; s < NCKPT; s++) begin
        for (int r = 0; r < NREG; r++) begin
          r_ck[s][r] <= w_ck_nxt[s][r];
        end
      end
    end
  end

endmodule

// File: tb/tb_rename_status_table.sv
// tb/tb_rename_status_table.sv - scoreboard bench for the rename status table
module tb_rename_status_table;

  localparam int NREG  = 32;
  localparam int ROBW  = 3;
  localparam int NCKPT = 4;
  localparam int IW    = 5;
  localparam int CW    = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [IW-1:0]   rs1, rs2;
  logic            src_busy1, src_busy2;
  logic [ROBW-1:0] src_tag1, src_tag2;
  logic            ren_valid;
  logic [IW-1:0]   ren_rd;
  logic [ROBW-1:0] ren_tag;
  logic            cmt_valid;
  logic [IW-1:0]   cmt_rd;
  logic [ROBW-1:0] cmt_tag;
  logic            ckpt_req;
  logic [CW-1:0]   ckpt_id;
  logic            ckpt_full;
  logic [CW:0]     ckpt_count;
  logic            release_valid;
  logic            restore_valid;
  logic [CW-1:0]   restore_id;
  logic            flush;

  always #5 clk = ~clk;

  rename_status_table #(
    .NREG  (NREG),
    .ROBW  (ROBW),
    .NCKPT (NCKPT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rs1           (rs1),
    .rs2           (rs2),
    .src_busy1     (src_busy1),
    .src_busy2     (src_busy2),
    .src_tag1      (src_tag1),
    .src_tag2      (src_tag2),
    .ren_valid     (ren_valid),
    .ren_rd        (ren_rd),
    .ren_tag       (ren_tag),
    .cmt_valid     (cmt_valid),
    .cmt_rd        (cmt_rd),
    .cmt_tag       (cmt_tag),
    .ckpt_req      (ckpt_req),
    .ckpt_id       (ckpt_id),
    .ckpt_full     (ckpt_full),
    .ckpt_count    (ckpt_count),
    .release_valid (release_valid),
    .restore_valid (restore_valid),
    .restore_id    (restore_id),
    .flush         (flush)
  );

  typedef struct packed {
    logic            b1;
    logic [ROBW-1:0] t1;
    logic            b2;
    logic [ROBW-1:0] t2;
    logic [CW-1:0]   id;
    logic            full;
    logic [CW:0]     cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  bit m_busy [NREG];
  int m_tag  [NREG];
  bit m_cb   [NCKPT][NREG];
  int m_ct   [NCKPT][NREG];
  int m_head, m_tail, m_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    reset = 0; rs1 = '0; rs2 = '0;
    ren_valid = 0; ren_rd = '0; ren_tag = '0;
    cmt_valid = 0; cmt_rd = '0; cmt_tag = '0;
    ckpt_req = 0; release_valid = 0; restore_valid = 0; restore_id = '0; flush = 0;
  endtask

  task automatic model_clear();
    for (int r = 0; r < NREG; r++) begin
      m_busy[r] = 0; m_tag[r] = 0;
      for (int s = 0; s < NCKPT; s++) begin m_cb[s][r] = 0; m_ct[s][r] = 0; end
    end
    m_head = 0; m_tail = 0; m_count = 0;
  endtask

  task automatic model_look(input int rs, output logic b, output logic [ROBW-1:0] t);
    if (rs != 0 && ren_valid && int'(ren_rd) == rs) begin
      b = 1; t = ren_tag;
    end else begin
      b = m_busy[rs];
      t = ROBW'(m_tag[rs]);
      if (rs == 0) b = 0;
      else if (cmt_valid && int'(cmt_rd) == rs && m_busy[rs] && m_tag[rs] == int'(cmt_tag)) b = 0;
    end
  endtask

  task automatic model_step();
    bit alloc, rel;
    int rid, crd;
    if (reset) begin
      model_clear();
    end else if (flush) begin
      for (int r = 0; r < NREG; r++) m_busy[r] = 0;
      m_head = 0; m_tail = 0; m_count = 0;
    end else begin
      crd = int'(cmt_rd);
      if (cmt_valid && crd != 0) begin
        for (int s = 0; s < NCKPT; s++)
          if (m_cb[s][crd] && m_ct[s][crd] == int'(cmt_tag)) m_cb[s][crd] = 0;
      end
      if (restore_valid) begin
        rid = int'(restore_id);
        for (int r = 0; r < NREG; r++) begin m_busy[r] = m_cb[rid][r]; m_tag[r] = m_ct[rid][r]; end
        if (cmt_valid && crd != 0 && m_busy[crd] && m_tag[crd] == int'(cmt_tag)) m_busy[crd] = 0;
        m_count = ((rid - m_head) % NCKPT + NCKPT) % NCKPT;
        m_tail  = rid;
      end else begin
        if (cmt_valid && crd != 0 && m_busy[crd] && m_tag[crd] == int'(cmt_tag)) m_busy[crd] = 0;
        if (ren_valid && ren_rd != 0) begin m_busy[ren_rd] = 1; m_tag[ren_rd] = int'(ren_tag); end
        alloc = ckpt_req && (m_count < NCKPT);
        rel   = release_valid && (m_count > 0);
        if (alloc) begin
          for (int r = 0; r < NREG; r++) begin m_cb[m_tail][r] = m_busy[r]; m_ct[m_tail][r] = m_tag[r]; end
          m_tail = (m_tail + 1) % NCKPT;
          m_count++;
        end
        if (rel) begin
          m_head = (m_head + 1) % NCKPT;
          m_count--;
        end
      end
    end
  endtask

  task automatic drive_and_check(input string name);
    exp_t e, ex;
    logic b;
    logic [ROBW-1:0] t;
    model_look(int'(rs1), b, t); e.b1 = b; e.t1 = t;
    model_look(int'(rs2), b, t); e.b2 = b; e.t2 = t;
    e.id   = CW'(m_tail);
    e.full = (m_count == NCKPT);
    e.cnt  = (CW+1)'(m_count);
    if (restore_valid && !reset && !flush)
      assert (((int'(restore_id) - m_head) % NCKPT + NCKPT) % NCKPT < m_count)
        else $error("restore_id %0d is not a live checkpoint", restore_id);
    sb_q.push_back(e);
    #3;
    if (sb_q.size() == 0) begin
      check({name, ".queue"}, 0, 1);
    end else begin
      ex = sb_q.pop_front();
      check({name, ".busy1"}, 32'(src_busy1), 32'(ex.b1));
      check({name, ".tag1"},  32'(src_tag1),  32'(ex.t1));
      check({name, ".busy2"}, 32'(src_busy2), 32'(ex.b2));
      check({name, ".tag2"},  32'(src_tag2),  32'(ex.t2));
      check({name, ".id"},    32'(ckpt_id),   32'(ex.id));
      check({name, ".full"},  32'(ckpt_full), 32'(ex.full));
      check({name, ".count"}, 32'(ckpt_count), 32'(ex.cnt));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string name);
    drive_and_check(name);
    tick();
  endtask

  initial begin
    idle();
    reset = 1;
    model_clear();
    @(posedge clk); #1;

    // reset holds and aborts a same-cycle rename and checkpoint
    reset = 1; rs1 = 5; ren_valid = 1; ren_rd = 5; ren_tag = 3; ckpt_req = 1;
    step("rst_abort");
    idle(); rs1 = 5; rs2 = 1;
    drive_and_check("post_rst");
    check("post_rst.x5", 32'(src_busy1), 0);
    check("post_rst.tag", 32'(src_tag1), 0);
    check("post_rst.cnt", 32'(ckpt_count), 0);
    check("post_rst.full", 32'(ckpt_full), 0);
    tick();

    // rename x5 tag 3, then commit it
    idle(); ren_valid = 1; ren_rd = 5; ren_tag = 3; rs1 = 5;
    drive_and_check("ren5_byp"); check("ren5_byp.b", 32'(src_busy1), 1); tick();
    idle(); rs1 = 5;
    drive_and_check("x5_busy"); check("x5_busy.b", 32'(src_busy1), 1); check("x5_busy.t", 32'(src_tag1), 3); tick();
    idle(); cmt_valid = 1; cmt_rd = 5; cmt_tag = 3; rs1 = 5;
    drive_and_check("cmt5_fwd"); check("cmt5_fwd.b", 32'(src_busy1), 0); tick();
    idle(); rs1 = 5; step("x5_free");

    // younger writer keeps register busy
    idle(); ren_valid = 1; ren_rd = 5; ren_tag = 2; step("ren5_t2");
    idle(); ren_valid = 1; ren_rd = 5; ren_tag = 6; step("ren5_t6");
    idle(); cmt_valid = 1; cmt_rd = 5; cmt_tag = 2; rs1 = 5;
    drive_and_check("cmt5_old"); check("cmt5_old.b", 32'(src_busy1), 1); check("cmt5_old.t", 32'(src_tag1), 6); tick();
    idle(); rs1 = 5;
    drive_and_check("x5_t6"); check("x5_t6.b", 32'(src_busy1), 1); check("x5_t6.t", 32'(src_tag1), 6); tick();

    // rename wins over a qualifying commit on the same register
    idle(); ren_valid = 1; ren_rd = 5; ren_tag = 1; cmt_valid = 1; cmt_rd = 5; cmt_tag = 6; rs1 = 5; step("ren_vs_cmt");
    idle(); rs1 = 5;
    drive_and_check("ren_wins"); check("ren_wins.b", 32'(src_busy1), 1); check("ren_wins.t", 32'(src_tag1), 1); tick();

    // x0 is never busy
    idle(); ren_valid = 1; ren_rd = 0; ren_tag = 1; rs1 = 0;
    drive_and_check("x0_ren"); check("x0_ren.b", 32'(src_busy1), 0); tick();
    idle(); rs1 = 0;
    drive_and_check("x0_after"); check("x0_after.b", 32'(src_busy1), 0); tick();

    // fill the ring, overflow, wrap
    for (int i = 0; i < 4; i++) begin
      idle(); ckpt_req = 1;
      drive_and_check("ck_fill"); check("ck_fill.id", 32'(ckpt_id), 32'(i)); tick();
    end
    idle(); ckpt_req = 1;
    drive_and_check("ck_over"); check("ck_over.full", 32'(ckpt_full), 1); check("ck_over.cnt", 32'(ckpt_count), 4); tick();
    idle(); release_valid = 1; step("ck_rel");
    idle(); ckpt_req = 1;
    drive_and_check("ck_wrap"); check("ck_wrap.id", 32'(ckpt_id), 0); check("ck_wrap.cnt", 32'(ckpt_count), 3); tick();
    idle();
    drive_and_check("ck_wrap2"); check("ck_wrap2.cnt", 32'(ckpt_count), 4); tick();

    // restore after a commit that only the checkpoint can see
    idle(); flush = 1; step("fl_a");
    idle(); ckpt_req = 1; step("ck0");
    idle(); ckpt_req = 1; ren_valid = 1; ren_rd = 7; ren_tag = 4; step("ck1_ren7");
    idle(); ren_valid = 1; ren_rd = 7; ren_tag = 5; step("ren7_t5");
    idle(); cmt_valid = 1; cmt_rd = 7; cmt_tag = 4; rs1 = 7;
    drive_and_check("cmt7_t4"); check("cmt7_t4.b", 32'(src_busy1), 1); check("cmt7_t4.t", 32'(src_tag1), 5); tick();
    idle(); restore_valid = 1; restore_id = 1; rs1 = 7; step("restore1");
    idle(); rs1 = 7;
    drive_and_check("rst1_after");
    check("rst1_after.b", 32'(src_busy1), 0); check("rst1_after.cnt", 32'(ckpt_count), 1); check("rst1_after.tail", 32'(ckpt_id), 1);
    tick();

    // restore with same-cycle commit; rename, allocate and release are ignored
    idle(); ckpt_req = 1; ren_valid = 1; ren_rd = 9; ren_tag = 2; step("ck_ren9");
    idle(); ren_valid = 1; ren_rd = 9; ren_tag = 7; step("ren9_t7");
    idle(); restore_valid = 1; restore_id = 1; cmt_valid = 1; cmt_rd = 9; cmt_tag = 2;
    ren_valid = 1; ren_rd = 3; ren_tag = 1; ckpt_req = 1; release_valid = 1; rs1 = 9; step("restore_cmt");
    idle(); rs1 = 9; rs2 = 3;
    drive_and_check("rc_after");
    check("rc_after.x9", 32'(src_busy1), 0); check("rc_after.x3", 32'(src_busy2), 0); check("rc_after.cnt", 32'(ckpt_count), 1);
    tick();

    // flush with live checkpoints and many busy registers
    idle(); flush = 1; step("fl_b");
    for (int i = 1; i <= 10; i++) begin
      idle(); ren_valid = 1; ren_rd = IW'(i); ren_tag = ROBW'(i); ckpt_req = (i == 3 || i == 6 || i == 9); rs1 = IW'(i);
      step("fill");
    end
    idle(); rs1 = 4;
    drive_and_check("pre_flush"); check("pre_flush.cnt", 32'(ckpt_count), 3); check("pre_flush.b", 32'(src_busy1), 1); tick();
    idle(); flush = 1; ren_valid = 1; ren_rd = 12; ren_tag = 5; ckpt_req = 1; release_valid = 1; step("flush");
    for (int i = 1; i <= 10; i++) begin
      idle(); rs1 = IW'(i); rs2 = 12;
      drive_and_check("post_flush");
      check("post_flush.b", 32'(src_busy1), 0);
      check("post_flush.cnt", 32'(ckpt_count), 0);
      check("post_flush.id", 32'(ckpt_id), 0);
      tick();
    end

    // random traffic against the model
    for (int c = 0; c < 300; c++) begin
      idle();
      rs1 = IW'($urandom_range(0, 7)); rs2 = IW'($urandom_range(0, 7));
      ren_valid = 1'($urandom_range(0, 1)); ren_rd = IW'($urandom_range(0, 7)); ren_tag = ROBW'($urandom_range(0, 7));
      cmt_valid = 1'($urandom_range(0, 1)); cmt_rd = IW'($urandom_range(0, 7));
      cmt_tag = ($urandom_range(0, 3) != 0) ? ROBW'(m_tag[cmt_rd]) : ROBW'($urandom_range(0, 7));
      ckpt_req = ($urandom_range(0, 2) == 0);
      release_valid = ($urandom_range(0, 4) == 0);
      if (m_count > 0 && $urandom_range(0, 9) == 0) begin
        restore_valid = 1;
        restore_id = CW'((m_head + int'($urandom_range(0, m_count - 1))) % NCKPT);
      end
      flush = ($urandom_range(0, 49) == 0);
      reset = ($urandom_range(0, 99) == 0);
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
